// File: rtl/seg_anim_pkg.sv
// Shared constants and frame-index type for the snake animation control path and its decoder.
package seg_anim_pkg;

  localparam int FRAMES = 20;
  localparam int IDX_W  = 5;

  typedef logic [IDX_W-1:0] frame_idx_t;

  localparam int TICK_DIV_DEF = 5000000;
  localparam int DEB_CYC_DEF  = 1000000;
  localparam int LONG_CYC_DEF = 50000000;

  // Wrapping step through 0..FRAMES-1 in either direction.
  function automatic frame_idx_t next_frame(input frame_idx_t cur, input logic fwd);
    if (fwd)
      return (cur == frame_idx_t'(FRAMES - 1)) ? '0 : cur + frame_idx_t'(1);
    else
      return (cur == '0) ? frame_idx_t'(FRAMES - 1) : cur - frame_idx_t'(1);
  endfunction

endpackage

// File: rtl/seg_anim_ctrl_pb_debounce.sv
// Two-flop synchroniser and level debouncer for the active-low pushbutton,
// with one-cycle pulses on accepted falling (press) and rising (release) edges.
module pb_debounce
  import seg_anim_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic level,
  output logic fall,
  output logic rise
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] deb_cnt;

  // The edge pulses are raised on the same edge that commits the new level,
  // so they are high for exactly the cycle after the level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      deb_cnt <= '0;
      fall    <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1 <= pb_n;
      sync2 <= sync1;
      fall  <= 1'b0;
      rise  <= 1'b0;
      if (sync2 == level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
        level   <= sync2;
        deb_cnt <= '0;
        fall    <= level;
        rise    <= ~level;
      end else begin
        deb_cnt <= deb_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seg_anim_ctrl.sv
// Control stage for the 4-digit snake animation: button handling, direction, step tick and frame index.
// Optional long-press pause/resume is enabled by defining SEG_ANIM_LONGPRESS_PAUSE_EN.
module seg_anim_ctrl
  import seg_anim_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int DEB_CYC  = DEB_CYC_DEF,
  parameter int LONG_CYC = LONG_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_n,
  output logic       press,
  output logic       dir,
  output logic       step,
  output frame_idx_t frame,
  output logic       paused
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);

  logic             db_level;
  logic             db_fall;
  logic             db_rise;
  logic [DIV_W-1:0] div_cnt;

  pb_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .pb_n  (pb_n),
    .level (db_level),
    .fall  (db_fall),
    .rise  (db_rise)
  );

`ifdef SEG_ANIM_LONGPRESS_PAUSE_EN
  localparam int HOLD_W = $clog2(LONG_CYC + 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              unused_fall;

  assign unused_fall = db_fall;

  // hold_cnt saturates at LONG_CYC once the pause has toggled, which also
  // marks the hold as long so its release does not count as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      paused   <= 1'b0;
      press    <= 1'b0;
    end else begin
      press <= db_rise && (hold_cnt != HOLD_W'(LONG_CYC));
      if (db_level) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_W'(LONG_CYC - 1)) begin
        hold_cnt <= HOLD_W'(LONG_CYC);
        paused   <= ~paused;
      end else if (hold_cnt != HOLD_W'(LONG_CYC)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end
`else
  localparam int unused_long_cyc = LONG_CYC;

  logic unused_db;

  assign unused_db = db_level ^ db_rise;
  assign press     = db_fall;
  assign paused    = 1'b0;
`endif

  // Frame moves with the dir value from before any same-edge toggle.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      step    <= 1'b0;
      frame   <= '0;
      dir     <= 1'b1;
    end else begin
      step <= 1'b0;
      if (!paused) begin
        if (div_cnt == DIV_W'(TICK_DIV - 1)) begin
          div_cnt <= '0;
          step    <= 1'b1;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        if (step)
          frame <= next_frame(frame, dir);
      end
      if (press)
        dir <= ~dir;
    end
  end

endmodule

// File: tb/tb_seg_anim_ctrl.sv
// Directed bench for seg_anim_ctrl with a small divider/debounce configuration.
module tb_seg_anim_ctrl;
  import seg_anim_pkg::*;

  typedef struct {
    string name;
    int    adv;
    logic  pb;
    int    exp_presses;
    logic  exp_dir;
    logic  exp_step;
    int    exp_frame;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       pb_n;
  logic       press;
  logic       dir;
  logic       step;
  frame_idx_t frame;
  logic       paused;

  int total_checks;
  int passed_checks;
  int presses;

  vec_t vecs[14];

  seg_anim_ctrl #(.TICK_DIV(4), .DEB_CYC(3), .LONG_CYC(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_n   (pb_n),
    .press  (press),
    .dir    (dir),
    .step   (step),
    .frame  (frame),
    .paused (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_checks++;
    if (actual == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Called at a negedge; drives pb_n, runs n cycles and counts press pulses seen.
  task automatic applyStimulus(input logic pb, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      pb_n = pb;
      @(posedge clk);
      @(negedge clk);
      if (press) cnt++;
    end
  endtask

  task automatic checkState(input string name, input int pc, input logic d, input logic s, input int f);
    checkOutput({name, ".presses"}, presses, pc);
    checkOutput({name, ".dir"}, int'(dir), int'(d));
    checkOutput({name, ".step"}, int'(step), int'(s));
    checkOutput({name, ".frame"}, int'(frame), f);
    checkOutput({name, ".paused"}, int'(paused), 0);
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    rst  = 1'b1;
    pb_n = 1'b1;

    vecs[0]  = '{"first_step",   4,  1'b1, 0, 1'b1, 1'b1, 0};
    vecs[1]  = '{"frame_1",      1,  1'b1, 0, 1'b1, 1'b0, 1};
    vecs[2]  = '{"step_2",       3,  1'b1, 0, 1'b1, 1'b1, 1};
    vecs[3]  = '{"frame_2",      1,  1'b1, 0, 1'b1, 1'b0, 2};
    vecs[4]  = '{"frame_19",     70, 1'b1, 0, 1'b1, 1'b0, 19};
    vecs[5]  = '{"step_20",      1,  1'b1, 0, 1'b1, 1'b1, 19};
    vecs[6]  = '{"fwd_wrap",     1,  1'b1, 0, 1'b1, 1'b0, 0};
    vecs[7]  = '{"glitch_low",   2,  1'b0, 0, 1'b1, 1'b0, 0};
    vecs[8]  = '{"glitch_done",  9,  1'b1, 0, 1'b1, 1'b1, 2};
    vecs[9]  = '{"press_dir",    8,  1'b0, 1, 1'b0, 1'b1, 4};
    vecs[10] = '{"first_rev",    1,  1'b1, 0, 1'b0, 1'b0, 3};
    vecs[11] = '{"rev_to_0",     15, 1'b1, 0, 1'b0, 1'b1, 0};
    vecs[12] = '{"rev_wrap",     1,  1'b1, 0, 1'b0, 1'b0, 19};
    vecs[13] = '{"mid_divider",  1,  1'b1, 0, 1'b0, 1'b0, 19};

    repeat (3) @(posedge clk);
    @(negedge clk);
    presses = 0;
    checkState("reset", 0, 1'b1, 1'b0, 0);
    checkOutput("reset.press", int'(press), 0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].pb, vecs[i].adv, presses);
      checkState(vecs[i].name, vecs[i].exp_presses, vecs[i].exp_dir,
                 vecs[i].exp_step, vecs[i].exp_frame);
    end

    // Reset pulsed for one cycle with dir reversed and the divider mid-count.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    presses = 0;
    checkState("midrst", 0, 1'b1, 1'b0, 0);
    checkOutput("midrst.press", int'(press), 0);
    rst = 1'b0;
    applyStimulus(1'b1, 3, presses);
    checkState("midrst_no_step", 0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1, presses);
    checkState("midrst_step", 0, 1'b1, 1'b1, 0);
    applyStimulus(1'b1, 15, presses);
    checkState("pre_coinc", 0, 1'b1, 1'b0, 4);

    // Press lands on the same cycle as the step that moves frame 5 -> 6.
    applyStimulus(1'b0, 5, presses);
    checkState("coinc", 1, 1'b1, 1'b1, 5);
    checkOutput("coinc.press_now", int'(press), 1);
    applyStimulus(1'b1, 1, presses);
    checkState("coinc_after", 0, 1'b0, 1'b0, 6);
    applyStimulus(1'b1, 4, presses);
    checkState("coinc_next", 0, 1'b0, 1'b0, 5);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/seg_anim_ctrl.md
Name: seg_anim_ctrl

Overview:
- Control stage directly upstream of the 4-digit seven-segment snake animation decoder.
- Synchronises and debounces the raw active-low pushbutton.
- Holds the direction flag, generates the frame-step tick from the system clock, and maintains the frame index.
- The decoder consumes frame and does combinational segment lookup only; there are no derived clocks, and everything is on clk.

Parameters:
- TICK_DIV, 5000000, system-clock cycles per animation step (100 ms at 50 MHz).
- DEB_CYC, 1000000, cycles a changed button level must persist before it is accepted.
- FRAMES, 20, number of animation frames; frame counts 0..FRAMES-1.
- IDX_W, 5, width of frame; must satisfy 2^IDX_W >= FRAMES.
- LONG_CYC, 50000000, hold time for a long press (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset; synchronous, active-high.
- pb_n, input, 1, raw pushbutton, active-low, asynchronous to clk.
- press, output, 1, one-cycle pulse on an accepted press.
- dir, output, 1, 1 = forward (frame increments), 0 = reverse.
- step, output, 1, one-cycle pulse, one per animation step.
- frame, output, IDX_W, current frame index, registered.
- paused, output, 1, animation frozen; tied 0 when the optional feature is out.

Behaviour:
- Reset (rst high at a clk edge):
  - press=0, dir=1, step=0, frame=0, paused=0.
  - Synchroniser flops=1, debounced level pb_db=1, all counters=0.
- Synchroniser: 2 flops on pb_n; the second-flop output is sync.
- Debounce:
  - When sync != pb_db, deb_cnt increments each cycle.
  - If the mismatch persists at deb_cnt==DEB_CYC-1, then pb_db<=sync and deb_cnt<=0.
  - Any cycle with sync==pb_db clears deb_cnt.
- press:
  - Registered; high for exactly the one cycle after pb_db goes 1->0.
  - If pb_n is first sampled low at edge k and stays low, press is high after edge k+DEB_CYC+1.
  - Release (0->1) is debounced the same way but produces no pulse.
  - Low pulses shorter than DEB_CYC sync cycles produce nothing.
- dir: toggles on the edge where press is 1.
- Tick divider:
  - div_cnt counts 0..TICK_DIV-1 and wraps.
  - step is registered high for one cycle each time div_cnt==TICK_DIV-1.
  - Period is exactly TICK_DIV cycles; the first step comes TICK_DIV cycles after rst deasserts.
- Frame update, on the edge where step is 1:
  - dir=1: frame==FRAMES-1 -> 0, else frame+1.
  - dir=0: frame==0 -> FRAMES-1, else frame-1.
  - frame never leaves 0..FRAMES-1.
- Simultaneous step and press: the frame update uses the pre-toggle dir; the new dir applies from the next step.
- Reset mid-operation: all state returns to the reset values at the next edge. If the button is held through reset, it is re-debounced after release and yields one press.

Optional Feature:
- Macro: SEG_ANIM_LONGPRESS_PAUSE_EN.
- Defined:
  - press and the dir toggle move to the debounced release, and occur only if the hold lasted < LONG_CYC cycles.
  - When pb_db has been 0 for LONG_CYC cycles, paused toggles once per hold.
  - While paused=1: div_cnt holds, step stays 0, frame freezes.
  - Resume continues from the held div_cnt.
- Undefined:
  - Press and dir toggle happen on press, as described in Behaviour.
  - No hold counter; paused is constant 0.

Decomposition:
- Package seg_anim_pkg holds:
  - FRAMES and IDX_W constants;
  - typedef frame_idx_t (logic [IDX_W-1:0]);
  - default TICK_DIV, DEB_CYC and LONG_CYC constants.
- The decoder imports the same package.
- One sub-module, pb_debounce: synchroniser + debounce + press/release edge pulses, parameterised by DEB_CYC.

Test Plan (TICK_DIV=4, DEB_CYC=3, FRAMES=20, LONG_CYC=10):
- Release rst, button idle -> step every 4 cycles; frame 0,1,...,19,0 over 20 steps; dir=1, press=0 throughout.
- pb_n low for 2 cycles then high -> press never asserted; dir stays 1.
- pb_n low for 8 cycles from edge k -> one press pulse after edge k+4, dir=0; the next step moves frame 0->19, then 18.
- press coincident with step at frame 5, dir=1 -> frame=6 and dir=0 on the same edge; the next step gives frame=5.
- rst pulsed one cycle at frame 7, dir=0, mid-divider -> next cycle frame=0, dir=1, step=0; the first step comes 4 cycles after rst falls.
- Macro defined: hold 12 cycles -> paused=1, frame frozen, dir unchanged, no press. Later 5-cycle hold -> press on release, dir toggles. Another 12-cycle hold -> paused=0, steps resume.
